// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// Module: button_conditioner
//
// Purpose
//   N-channel push-button conditioner sitting between raw board keys and the
//   game / VGA logic. Each channel is an independent pipeline:
//     polarity normalisation -> 2-flop synchroniser -> counter debouncer
//     -> press/release edge pulses -> auto-repeat pulse generator.
//   All outputs are registered.
//
// Parameters
//   N_CH            number of button channels
//   ACTIVE_LOW      1: raw pin low means pressed; 0: raw pin high means pressed
//   DEBOUNCE_CYCLES consecutive disagreeing cycles before a new level is taken (>=1)
//   REPEAT_DELAY    hold cycles after the press pulse before the first repeat;
//                   0 turns auto-repeat off (only the press-time repeat pulse fires)
//   REPEAT_RATE     cycles between later repeats (>=1)
//
// Ports
//   clock        in   1      system clock, single domain
//   reset        in   1      synchronous, active-high reset
//   btn_raw      in   N_CH   asynchronous raw button pins
//   btn_level    out  N_CH   debounced level, 1 = pressed
//   btn_press    out  N_CH   1-cycle pulse when the debounced level rises
//   btn_release  out  N_CH   1-cycle pulse when the debounced level falls
//   btn_repeat   out  N_CH   1-cycle pulse at press, then at each auto-repeat instant
//   any_level    out  1      OR of btn_level, registered alongside it
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_CH            = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat,
  output logic            any_level
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps.
  localparam int DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Repeat counter is shared between the delay and rate phases, so it is
  // sized for whichever interval is longer.
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W   = (RC_MAX > 0) ? $clog2(RC_MAX + 1) : 1;

  localparam logic [DC_W-1:0] DB_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [RC_W-1:0] RR_LAST = RC_W'(REPEAT_RATE - 1);
  localparam bit              REPEAT_EN = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rptState_e;

  // Synchroniser and debounced state
  logic [N_CH-1:0] syncIn;
  logic [N_CH-1:0] s1_q;
  logic [N_CH-1:0] s2_q;
  logic [N_CH-1:0] level_q;
  logic [N_CH-1:0] level_d;
  logic [DC_W-1:0] dcnt_q [N_CH];
  logic [DC_W-1:0] dcnt_d [N_CH];

  // Edge detection of the debounced level
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  // Registered pulse outputs
  logic [N_CH-1:0] press_q;
  logic [N_CH-1:0] release_q;
  logic [N_CH-1:0] repeat_q;
  logic [N_CH-1:0] repeat_d;
  logic            any_q;

  // Auto-repeat state per channel
  rptState_e       state_q [N_CH];
  rptState_e       state_d [N_CH];
  logic [RC_W-1:0] rc_q    [N_CH];
  logic [RC_W-1:0] rc_d    [N_CH];

  // Normalise polarity before the synchroniser so every internal signal
  // reads 1 = pressed and the released reset value is simply 0.
  assign syncIn = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Debouncer: a channel's level only moves after the synchronised input has
  // disagreed with it on DEBOUNCE_CYCLES consecutive edges. A single cycle of
  // agreement throws away the partial count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_CH; i++) begin
      dcnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DC_W'(1);
        end
      end
    end
  end

  // Edges are taken from the next-state level so the pulses register on the
  // very edge where btn_level itself changes.
  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // Auto-repeat FSM: IDLE waits for a press, DELAY counts the initial hold
  // interval, REPEAT then fires every REPEAT_RATE cycles. A release beats
  // any repeat that would otherwise fire on the same edge.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      rc_d[i]    = rc_q[i];
      if (fall[i]) begin
        state_d[i] = IDLE;
        rc_d[i]    = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              repeat_d[i] = 1'b1;
              rc_d[i]     = '0;
              state_d[i]  = REPEAT_EN ? DELAY : IDLE;
            end
          end
          DELAY: begin
            if (rc_q[i] == RD_LAST) begin
              repeat_d[i] = 1'b1;
              rc_d[i]     = '0;
              state_d[i]  = REPEAT;
            end else begin
              rc_d[i] = rc_q[i] + RC_W'(1);
            end
          end
          REPEAT: begin
            if (rc_q[i] == RR_LAST) begin
              repeat_d[i] = 1'b1;
              rc_d[i]     = '0;
            end else begin
              rc_d[i] = rc_q[i] + RC_W'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            rc_d[i]    = '0;
          end
        endcase
      end
    end
  end

  // All state and outputs. Reset wins over everything on the same edge, so
  // a reset in the middle of a debounce or repeat sequence leaves no stray
  // pulse behind, and the synchroniser restarts from "released".
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        dcnt_q[i]  <= '0;
        rc_q[i]    <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      s1_q      <= syncIn;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= rise;
      release_q <= fall;
      repeat_q  <= repeat_d;
      any_q     <= |level_d;
      for (int i = 0; i < N_CH; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        rc_q[i]    <= rc_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign any_level   = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for button_conditioner.
// Two instances share the same raw pins: dutA uses auto-repeat
// (REPEAT_DELAY=10), dutB has auto-repeat disabled (REPEAT_DELAY=0).
// A behavioural model describes each channel in terms of "how many
// consecutive samples disagreed" and "how long has the key been held", and is
// compared with both instances every cycle. Directed sequences add literal
// expectations at the key instants.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'b0000;

  logic [3:0] levA, pressA, relA, repA;
  logic       anyA;
  logic [3:0] levB, pressB, relB, repB;
  logic       anyB;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  button_conditioner #(
    .N_CH(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dutA (
    .clock(clock), .reset(reset), .btn_raw(btn_raw),
    .btn_level(levA), .btn_press(pressA), .btn_release(relA),
    .btn_repeat(repA), .any_level(anyA)
  );

  button_conditioner #(
    .N_CH(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(0), .REPEAT_RATE(RR)
  ) dutB (
    .clock(clock), .reset(reset), .btn_raw(btn_raw),
    .btn_level(levB), .btn_press(pressB), .btn_release(relB),
    .btn_repeat(repB), .any_level(anyB)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [3:0] mP1, mP2, mLevel, mPress, mRel, mRepA, mRepB;
  logic       mAny;
  int         streak [4];
  int         held   [4];

  // A repeat is due at the press instant and then, when repeat is enabled,
  // at every rd + k*RR cycles of continuous hold.
  function automatic logic repeatDue(input int t, input int rd);
    if (t < 0) return 1'b0;
    if (t == 0) return 1'b1;
    if (rd == 0 || t < rd) return 1'b0;
    return ((t - rd) % RR) == 0;
  endfunction

  always @(posedge clock) begin : modelStep
    logic [3:0] nl;
    int         nStreak;
    int         nHeld;
    if (reset) begin
      mP1 <= '0; mP2 <= '0; mLevel <= '0; mPress <= '0; mRel <= '0;
      mRepA <= '0; mRepB <= '0; mAny <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        streak[i] <= 0;
        held[i]   <= -1;
      end
    end else begin
      nl = mLevel;
      for (int i = 0; i < 4; i++) begin
        nStreak = (mP2[i] != mLevel[i]) ? streak[i] + 1 : 0;
        if (nStreak == DB) begin
          nl[i]   = mP2[i];
          nStreak = 0;
        end
        streak[i] <= nStreak;
        if (nl[i] && !mLevel[i]) nHeld = 0;
        else if (nl[i])          nHeld = held[i] + 1;
        else                     nHeld = -1;
        held[i]  <= nHeld;
        mRepA[i] <= repeatDue(nHeld, RD);
        mRepB[i] <= repeatDue(nHeld, 0);
      end
      mP1    <= ~btn_raw;
      mP2    <= mP1;
      mLevel <= nl;
      mPress <= nl & ~mLevel;
      mRel   <= ~nl & mLevel;
      mAny   <= |nl;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Per-cycle comparison of both instances against the model, sampled on the
  // falling edge, away from the active edge.
  always @(negedge clock) begin
    cycle++;
    checkOutput($sformatf("model dutA cyc%0d", cycle),
                32'({levA, pressA, relA, repA, anyA}),
                32'({mLevel, mPress, mRel, mRepA, mAny}));
    checkOutput($sformatf("model dutB cyc%0d", cycle),
                32'({levB, pressB, relB, repB, anyB}),
                32'({mLevel, mPress, mRel, mRepB, mAny}));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [3:0] raw, input int n);
    btn_raw = raw;
    tick(n);
  endtask

  logic [30:0] expMask;
  logic [3:0]  bouncePat [7];
  int          cntB;

  initial begin
    expMask   = 31'h12492400;  // offsets 10,13,16,19,22,25,28
    bouncePat = '{4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1101, 4'b1101, 4'b1101};

    // Reset with every key pressed on the raw pins
    reset   = 1'b1;
    btn_raw = 4'b0000;
    tick(3);
    checkOutput("reset outputs A", 32'({levA, pressA, relA, repA, anyA}), 32'd0);
    checkOutput("reset outputs B", 32'({levB, pressB, relB, repB, anyB}), 32'd0);
    reset = 1'b0;
    tick(5);
    checkOutput("post-reset level at 5", 32'(levA), 32'h0);
    checkOutput("post-reset press at 5", 32'(pressA), 32'h0);
    tick(1);
    checkOutput("post-reset level at 6", 32'(levA), 32'hf);
    checkOutput("post-reset press at 6", 32'(pressA), 32'hf);
    checkOutput("post-reset any", 32'(anyA), 32'h1);
    applyStimulus(4'b1111, 6);
    checkOutput("all release", 32'(relA), 32'hf);
    checkOutput("all level low", 32'(levA), 32'h0);
    tick(4);

    // Clean press on ch0, released so the level falls exactly at press+10
    applyStimulus(4'b1110, 5);
    checkOutput("ch0 level at 5", 32'(levA), 32'h0);
    tick(1);
    checkOutput("ch0 level", 32'(levA), 32'h1);
    checkOutput("ch0 press", 32'(pressA), 32'h1);
    checkOutput("ch0 repeat", 32'(repA), 32'h1);
    tick(1);
    checkOutput("ch0 press 1 cycle", 32'(pressA), 32'h0);
    tick(3);
    applyStimulus(4'b1111, 5);
    checkOutput("ch0 still held", 32'(levA), 32'h1);
    tick(1);
    checkOutput("ch0 release", 32'(relA), 32'h1);
    checkOutput("ch0 no repeat on release", 32'(repA), 32'h0);
    tick(4);

    // Bounce on ch1 never reaches four consecutive disagreements
    for (int k = 0; k < 7; k++) begin
      applyStimulus(bouncePat[k], 1);
      checkOutput($sformatf("ch1 bounce level step%0d", k), 32'(levA[1]), 32'h0);
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 1);
      checkOutput($sformatf("ch1 bounce press step%0d", k), 32'(pressA[1]), 32'h0);
    end

    // Auto-repeat on ch2 held 30 cycles after the press
    applyStimulus(4'b1011, 6);
    checkOutput("ch2 press", 32'(pressA), 32'h4);
    checkOutput("ch2 repeat +0", 32'(repA), 32'h4);
    checkOutput("ch2 dutB repeat +0", 32'(repB), 32'h4);
    cntB = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      checkOutput($sformatf("ch2 repeat +%0d", k), 32'(repA[2]), 32'(expMask[k]));
      cntB += int'(repB[2]);
    end
    checkOutput("ch2 dutB extra repeats", 32'(cntB), 32'd0);
    applyStimulus(4'b1111, 5);
    checkOutput("ch2 held before release", 32'(levA[2]), 32'h1);
    tick(1);
    checkOutput("ch2 release", 32'(relA), 32'h4);
    checkOutput("ch2 repeat stopped", 32'(repA), 32'h0);
    tick(4);

    // Reset in the middle of a repeat sequence on ch3
    applyStimulus(4'b0111, 6);
    checkOutput("ch3 press", 32'(pressA), 32'h8);
    tick(12);
    reset = 1'b1;
    tick(1);
    checkOutput("mid-repeat reset A", 32'({levA, pressA, relA, repA, anyA}), 32'd0);
    checkOutput("mid-repeat reset B", 32'({levB, pressB, relB, repB, anyB}), 32'd0);
    reset = 1'b0;
    tick(5);
    checkOutput("ch3 level after reset at 5", 32'(levA), 32'h0);
    tick(1);
    checkOutput("ch3 re-press", 32'(pressA), 32'h8);
    checkOutput("ch3 repeat restart +0", 32'(repA), 32'h8);
    tick(10);
    checkOutput("ch3 repeat restart +10", 32'(repA), 32'h8);
    tick(1);
    checkOutput("ch3 repeat +11 quiet", 32'(repA), 32'h0);
    applyStimulus(4'b1111, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
